// File: rtl/octal_sub_seq.sv
// rtl/octal_sub_seq.sv - digit-serial octal subtractor, one digit per clock, LSD first.
// Define OCTAL_SUB_SAT_EN to clamp negative results to zero (B_out still reports the borrow).
module octal_sub_seq #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3*DIGITS-1:0]   A,
  input  logic [3*DIGITS-1:0]   B,
  output logic [3*DIGITS-1:0]   diff,
  output logic                  B_out,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 3 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic           r_borrow;
  logic [IW-1:0]  r_idx;
  logic [3:0]     w_t;
  logic [W-1:0]   w_res_next;
  logic           w_last;

  // Operands shift right each step, so the active digit is always bits [2:0];
  // bit 3 of the 4-bit difference is the borrow and bits [2:0] equal t+8 when t<0.
  assign w_t        = {1'b0, r_a[2:0]} - {1'b0, r_b[2:0]} - {3'b000, r_borrow};
  assign w_res_next = W'({w_t[2:0], r_res} >> 3);
  assign w_last     = (r_idx == IW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = CALC;
      CALC:    if (w_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == CALC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      diff     <= '0;
      B_out    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
          end
        end
        CALC: begin
          r_a      <= r_a >> 3;
          r_b      <= r_b >> 3;
          r_res    <= w_res_next;
          r_borrow <= w_t[3];
          r_idx    <= r_idx + IW'(1);
          if (w_last) begin
            r_idx <= '0;
            B_out <= w_t[3];
            done  <= 1'b1;
`ifdef OCTAL_SUB_SAT_EN
            diff  <= w_t[3] ? '0 : w_res_next;
`else
            diff  <= w_res_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_octal_sub_seq.sv
// tb/tb_octal_sub_seq.sv - scoreboard bench for octal_sub_seq with randomized traffic.
module tb_octal_sub_seq;

  localparam int D = 3;
  localparam int W = 3 * D;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] diff;
  logic         B_out;
  logic         busy;
  logic         done;

  exp_t         q[$];
  int           cyc = 0;
  int           acc = 0;
  int           last_done = 0;
  int           checks = 0;
  int           failures = 0;
  logic         mon_en = 1'b0;
  logic         rst_seen = 1'b0;
  logic [W-1:0] cur_d = '0;
  logic         cur_b = 1'b0;

  octal_sub_seq #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .diff  (diff),
    .B_out (B_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  // Reference: plain integer subtraction modulo 8^D, borrow when A < B.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t   e;
    longint ai = longint'(a);
    longint bi = longint'(b);
    longint m  = longint'(1) << W;
    e.bo  = (ai < bi);
    e.d   = W'((ai - bi + m) % m);
`ifdef OCTAL_SUB_SAT_EN
    if (e.bo) e.d = '0;
`endif
    e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive a start; the bench knows the block is idle once the previous done cycle is reached.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    if (cyc >= last_done) begin
      q.push_back(model(a, b, cyc + 1 + D));
      acc       = cyc + 1;
      last_done = cyc + 1 + D;
    end
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #2;
    issue(a, b);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || cyc < last_done) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=%0d required=%0d", q.size(), 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        cur_d = '0;
        cur_b = 1'b0;
      end
      chk("busy", 32'(busy), 32'(cyc >= acc && cyc < last_done));
      while (q.size() != 0 && q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_done actual=%0d required=%0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=%0d required=%0d", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("diff_on_done", 32'(diff), 32'(e.d));
          chk("bout_on_done", 32'(B_out), 32'(e.bo));
          cur_d = e.d;
          cur_b = e.bo;
        end
      end
      chk("held_outputs", 32'({B_out, diff}), 32'({cur_b, cur_d}));
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #2 mon_en = 1'b1;
    @(negedge clk);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(B_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    do_start(9'o765, 9'o123);
    wait_idle();
    chk("basic_diff", 32'(diff), 32'(9'o642));
    chk("basic_bout", 32'(B_out), 32'd0);

    do_start(9'o100, 9'o001);
    wait_idle();
    chk("ripple_diff", 32'(diff), 32'(9'o077));
    chk("ripple_bout", 32'(B_out), 32'd0);

    do_start(9'o000, 9'o001);
    wait_idle();
`ifdef OCTAL_SUB_SAT_EN
    chk("under_diff", 32'(diff), 32'(9'o000));
`else
    chk("under_diff", 32'(diff), 32'(9'o777));
`endif
    chk("under_bout", 32'(B_out), 32'd1);

    // Start while busy, then scramble operands mid-run.
    @(posedge clk); #2;
    issue(9'o500, 9'o200);
    @(posedge clk); #2;
    issue(9'o777, 9'o000);
    @(posedge clk); #2;
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    wait_idle();
    chk("ignore_diff", 32'(diff), 32'(9'o300));
    chk("ignore_bout", 32'(B_out), 32'd0);

    // Reset one cycle after start abandons the operation.
    do_start(9'o456, 9'o123);
    rst_n = 1'b0;
    @(posedge clk); #2;
    q.delete();
    acc       = 0;
    last_done = 0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(B_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (6) @(posedge clk);
    #2;
    do_start(9'o654, 9'o321);
    wait_idle();
    chk("post_abort_diff", 32'(diff), 32'(9'o333));

    // Start held high through done: the second op is accepted in the done cycle.
    @(posedge clk); #2;
    issue(9'o321, 9'o123);
    repeat (D + 1) begin
      @(posedge clk); #2;
      issue(9'o007, 9'o007);
    end
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    chk("b2b_diff", 32'(diff), 32'd0);
    chk("b2b_bout", 32'(B_out), 32'd0);

    repeat (400) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 2) == 0) begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        ra = W'($urandom);
        rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
        issue(ra, rb);
      end else begin
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
      end
    end
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
